// File: rtl/key_debouncer_if.sv
// Key conditioning bus: raw pin levels in, clean levels and one-cycle event pulses out.
interface key_debouncer_if #(
  parameter int NUM_KEYS = 9
);
  logic [NUM_KEYS-1:0] raw_keys;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;
  logic [NUM_KEYS-1:0] key_event;

  modport master (
    output raw_keys,
    input  key_level, key_press, key_release, key_repeat, key_event
  );

  modport slave (
    input  raw_keys,
    output key_level, key_press, key_release, key_repeat, key_event
  );
endinterface

// File: rtl/key_debouncer.sv
// Per-key 2-FF synchroniser, stability-counter debouncer and auto-repeat FSM
// producing clean levels plus registered press/release/repeat/event pulses.
module key_debouncer #(
  parameter int                  NUM_KEYS        = 9,
  parameter int                  DEBOUNCE_CYCLES = 500000,
  parameter int                  REPEAT_DELAY    = 25000000,
  parameter int                  REPEAT_PERIOD   = 5000000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = 9'h00F
) (
  input  logic           sysclk,
  input  logic           rst,
  key_debouncer_if.slave bus
);

  localparam int DCW  = $clog2(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX);

  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] RP_LAST = RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rep_state_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_level;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic [NUM_KEYS-1:0] r_repeat;
  logic [NUM_KEYS-1:0] r_event;
  logic [DCW-1:0]      r_dcnt  [NUM_KEYS];
  logic [RCW-1:0]      r_rcnt  [NUM_KEYS];
  rep_state_t          r_state [NUM_KEYS];

  logic [NUM_KEYS-1:0] w_rise;
  logic [NUM_KEYS-1:0] w_fall;
  logic [NUM_KEYS-1:0] w_rep;

  // Flip and terminal-count decisions for this edge; a release flip suppresses any repeat.
  always_comb begin
    w_rise = '0;
    w_fall = '0;
    w_rep  = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_rise[k] = (r_dcnt[k] == DC_LAST) && r_sync2[k] && !r_level[k];
      w_fall[k] = (r_dcnt[k] == DC_LAST) && !r_sync2[k] && r_level[k];
      w_rep[k]  = REPEAT_MASK[k] && !w_fall[k] &&
                  (((r_state[k] == ST_DELAY)  && (r_rcnt[k] == RD_LAST)) ||
                   ((r_state[k] == ST_REPEAT) && (r_rcnt[k] == RP_LAST)));
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_repeat  <= '0;
      r_event   <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_dcnt[k]  <= '0;
        r_rcnt[k]  <= '0;
        r_state[k] <= ST_IDLE;
      end
    end else begin
      r_sync1   <= bus.raw_keys;
      r_sync2   <= r_sync1;
      r_level   <= r_level ^ (w_rise | w_fall);
      r_press   <= w_rise;
      r_release <= w_fall;
      r_repeat  <= w_rep;
      r_event   <= w_rise | w_rep;
      for (int k = 0; k < NUM_KEYS; k++) begin
        // Any sample agreeing with the stable level restarts the stability count.
        if ((r_sync2[k] == r_level[k]) || (r_dcnt[k] == DC_LAST))
          r_dcnt[k] <= '0;
        else
          r_dcnt[k] <= r_dcnt[k] + 1'b1;

        if (!REPEAT_MASK[k]) begin
          r_state[k] <= ST_IDLE;
          r_rcnt[k]  <= '0;
        end else begin
          case (r_state[k])
            ST_IDLE: begin
              if (w_rise[k]) begin
                r_state[k] <= ST_DELAY;
                r_rcnt[k]  <= '0;
              end
            end
            ST_DELAY: begin
              if (w_fall[k]) begin
                r_state[k] <= ST_IDLE;
                r_rcnt[k]  <= '0;
              end else if (r_rcnt[k] == RD_LAST) begin
                r_state[k] <= ST_REPEAT;
                r_rcnt[k]  <= '0;
              end else begin
                r_rcnt[k] <= r_rcnt[k] + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (w_fall[k]) begin
                r_state[k] <= ST_IDLE;
                r_rcnt[k]  <= '0;
              end else if (r_rcnt[k] == RP_LAST) begin
                r_rcnt[k] <= '0;
              end else begin
                r_rcnt[k] <= r_rcnt[k] + 1'b1;
              end
            end
            default: begin
              r_state[k] <= ST_IDLE;
              r_rcnt[k]  <= '0;
            end
          endcase
        end
      end
    end
  end

  assign bus.key_level   = r_level;
  assign bus.key_press   = r_press;
  assign bus.key_release = r_release;
  assign bus.key_repeat  = r_repeat;
  assign bus.key_event   = r_event;

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: directed scenarios plus random key activity,
// checked every cycle against a timestamp-based reference model.
module tb_key_debouncer;

  localparam int              NK   = 9;
  localparam int              DC   = 4;
  localparam int              RD   = 10;
  localparam int              RP   = 3;
  localparam logic [NK-1:0]   MASK = 9'h00F;

  logic          sysclk;
  logic          rst;
  logic [NK-1:0] rawKeys;

  int errors;
  int checks;
  int cyc;

  logic [NK-1:0] syncQ [$];
  int            streak [NK];
  int            pressAt [NK];
  logic [NK-1:0] mLevel;
  logic [NK-1:0] expLevel, expPress, expRelease, expRepeat, expEvent;

  key_debouncer_if #(.NUM_KEYS(NK)) bus ();

  assign bus.raw_keys = rawKeys;

  key_debouncer #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK(MASK)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // Reference: a level flips after DC consecutive disagreeing synchronised samples;
  // repeats fall at pressAt + RD + n*RP while held, except on the release edge.
  task automatic modelStep();
    logic [NK-1:0] used;
    logic          wasHigh;
    cyc++;
    expPress   = '0;
    expRelease = '0;
    expRepeat  = '0;
    if (rst) begin
      syncQ.delete();
      syncQ.push_back('0);
      syncQ.push_back('0);
      mLevel = '0;
      for (int k = 0; k < NK; k++) begin
        streak[k]  = 0;
        pressAt[k] = 0;
      end
    end else begin
      used = syncQ.pop_front();
      syncQ.push_back(rawKeys);
      for (int k = 0; k < NK; k++) begin
        wasHigh = mLevel[k];
        if (used[k] == wasHigh) streak[k] = 0;
        else streak[k]++;
        if (streak[k] == DC) begin
          streak[k] = 0;
          mLevel[k] = ~wasHigh;
          if (!wasHigh) begin
            expPress[k] = 1'b1;
            pressAt[k]  = cyc;
          end else begin
            expRelease[k] = 1'b1;
          end
        end
        if (MASK[k] && wasHigh && !expRelease[k] && (cyc - pressAt[k]) >= RD &&
            ((cyc - pressAt[k] - RD) % RP) == 0)
          expRepeat[k] = 1'b1;
      end
    end
    expLevel = mLevel;
    expEvent = expPress | expRepeat;
  endtask

  task automatic checkVec(string tag, logic [NK-1:0] got, logic [NK-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic checkBit(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkVec("level",   bus.key_level,   expLevel);
    checkVec("press",   bus.key_press,   expPress);
    checkVec("release", bus.key_release, expRelease);
    checkVec("repeat",  bus.key_repeat,  expRepeat);
    checkVec("event",   bus.key_event,   expEvent);
  endtask

  task automatic tick();
    @(posedge sysclk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    cyc     = 0;
    rst     = 1'b1;
    rawKeys = '0;
    applyStimulus(2);
    rst = 1'b0;
    applyStimulus(8);

    $display("[TB] clean press on key 0");
    rawKeys[0] = 1'b1;
    applyStimulus(5);
    tick();
    checkBit("t1_press0", bus.key_press[0], 1'b1);
    checkBit("t1_event0", bus.key_event[0], 1'b1);
    tick();
    checkBit("t1_press0_once", bus.key_press[0], 1'b0);
    applyStimulus(6);
    rawKeys[0] = 1'b0;
    applyStimulus(10);

    $display("[TB] bouncing key 1");
    for (int b = 0; b < 2; b++) begin
      rawKeys[1] = 1'b1;
      applyStimulus(2);
      rawKeys[1] = 1'b0;
      applyStimulus(2);
    end
    rawKeys[1] = 1'b1;
    applyStimulus(5);
    tick();
    checkBit("t2_press1", bus.key_press[1], 1'b1);
    applyStimulus(8);
    rawKeys[1] = 1'b0;
    applyStimulus(10);

    $display("[TB] auto-repeat on key 2");
    rawKeys[2] = 1'b1;
    applyStimulus(30);
    rawKeys[2] = 1'b0;
    applyStimulus(12);

    $display("[TB] masked key 8");
    rawKeys[8] = 1'b1;
    applyStimulus(50);
    rawKeys[8] = 1'b0;
    applyStimulus(10);

    $display("[TB] release/repeat collision on key 3");
    rawKeys[3] = 1'b1;
    applyStimulus(13);
    rawKeys[3] = 1'b0;
    applyStimulus(5);
    tick();
    checkBit("t5_release3", bus.key_release[3], 1'b1);
    checkBit("t5_repeat3",  bus.key_repeat[3],  1'b0);
    checkBit("t5_event3",   bus.key_event[3],   1'b0);
    applyStimulus(6);

    $display("[TB] reset while key 0 repeats");
    rawKeys[0] = 1'b1;
    applyStimulus(20);
    rst = 1'b1;
    tick();
    checkVec("t6_rst_level", bus.key_level, '0);
    rst = 1'b0;
    applyStimulus(5);
    tick();
    checkBit("t6_repress0", bus.key_press[0], 1'b1);
    applyStimulus(4);
    rawKeys[0] = 1'b0;
    applyStimulus(10);

    $display("[TB] random key activity");
    for (int i = 0; i < 200; i++) begin
      int b;
      b = int'($urandom_range(0, NK - 1));
      rawKeys[b] = ~rawKeys[b];
      if ($urandom_range(0, 49) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(int'($urandom_range(0, 20)));
    end
    rawKeys = '0;
    applyStimulus(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Front-end conditioning stage between the board push-buttons/slide switches and keyboard_proc.
- Synchronises each raw key to sysclk and debounces it with a per-key stability counter.
- Emits a clean level, one-cycle press/release pulses, and optional auto-repeat pulses for held keys.
- keyboard_proc and the f*_keyproc blocks consume the clean levels and event pulses instead of raw pins.

Parameters:
NUM_KEYS, 9, number of independent key inputs (East, West, North, South, SW0-SW3, change_button).
DEBOUNCE_CYCLES, 500000, consecutive sysclk cycles a synchronised input must differ from the stable value before the stable value flips (10 ms at 50 MHz); legal range >=2.
REPEAT_DELAY, 25000000, cycles from the press pulse to the first repeat pulse (0.5 s); legal range >=2.
REPEAT_PERIOD, 5000000, cycles between successive repeat pulses (0.1 s); legal range >=2.
REPEAT_MASK, 9'h00F, bit k=1 enables auto-repeat for key k; default enables the four direction keys.

Ports:
sysclk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
raw_keys  input  NUM_KEYS  asynchronous raw pin levels, 1 = pressed/on
key_level  output  NUM_KEYS  debounced stable level per key
key_press  output  NUM_KEYS  one-cycle pulse when key_level rises
key_release  output  NUM_KEYS  one-cycle pulse when key_level falls
key_repeat  output  NUM_KEYS  one-cycle auto-repeat pulse while held (masked keys only)
key_event  output  NUM_KEYS  key_press OR key_repeat, registered identically

Behaviour:
- Clock/reset: one clock (sysclk); reset is synchronous, active-high (rst).
- rst (sampled high on an edge) clears synchronisers, stable levels, debounce counters, repeat counters and repeat state.
  - All outputs read 0 after that edge.
  - A key physically held through reset is treated as a fresh press once debounced after rst falls.
- Synchroniser: per key, 2-FF chain raw -> s1 -> s2. Only s2 is used downstream.
- Debounce, per key; counter width = $clog2(DEBOUNCE_CYCLES) bits, no overflow possible:
  - s2 == key_level: counter <= 0.
  - s2 != key_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - s2 != key_level and counter == DEBOUNCE_CYCLES-1: key_level <= s2, counter <= 0.
  - Any bounce (s2 returning to key_level) restarts the count from 0.
  - Latency: raw held constant from edge E flips key_level on edge E+DEBOUNCE_CYCLES+1.
- Pulses are registered and assert on the same edge key_level changes, for exactly one cycle.
  - key_press on a 0->1 flip; key_release on a 1->0 flip.
  - Never both in the same cycle for one key.
- Auto-repeat FSM, per key with REPEAT_MASK[k]=1; masked-off keys stay in IDLE and key_repeat[k] is constant 0:
  - IDLE: on the press flip, go to DELAY with rcnt <= 0.
  - DELAY: rcnt increments each cycle. When rcnt == REPEAT_DELAY-1: assert key_repeat, rcnt <= 0, go to REPEAT.
  - REPEAT: rcnt increments. When rcnt == REPEAT_PERIOD-1: assert key_repeat, rcnt <= 0.
  - In DELAY or REPEAT, the release flip forces IDLE and rcnt <= 0 on that edge.
  - Release wins: if the release flip and a repeat terminal count fall on the same edge, no key_repeat is emitted.
  - Repeat counter width = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)).
- key_event = key_press | key_repeat, computed from next-state values and registered, so it aligns exactly with those pulses.
- Keys are fully independent: simultaneous activity on several keys produces simultaneous per-bit pulses with no arbitration.
- Switch inputs (SW0-SW3) use the same path. Their key_level is the meaningful output; press/release pulses are available.

Test Plan:
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, NUM_KEYS=9, REPEAT_MASK=9'h00F.
1. Clean press: raw_keys[0] 0->1 at edge 10, held -> key_level[0] and key_press[0] rise at edge 15; key_press[0] high exactly 1 cycle; key_event[0] matches.
2. Bounce: raw_keys[1] toggles 1,0,1,0 every 2 cycles, then held 1 -> no pulse during toggling; key_press[1] exactly once, 5 edges after the final 0->1.
3. Auto-repeat: hold key 2 -> key_repeat[2] 10 cycles after key_press[2], then every 3 cycles; release -> key_release[2] pulse, repeats stop on that edge.
4. Masked key: hold key 8 (change_button) for 50 cycles -> one key_press[8], key_repeat[8] stays 0, one key_release[8] after release.
5. Release/repeat collision: align the release flip of key 3 with its repeat terminal count -> key_release[3]=1, key_repeat[3]=0, key_event[3]=0 on that edge.
6. Reset mid-operation: key 0 in REPEAT, assert rst 1 cycle with raw still high -> all outputs 0 next edge; after rst falls, key_press[0] re-asserts 5 edges later.
